// File: rtl/rv32im_bus_responder.sv
// Wishbone-classic memory responder: window decode, wait-state insertion,
// byte-masked synchronous RAM, err_o termination for out-of-window accesses.
module rv32im_bus_responder #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int BASE_WORD   = 0,
   parameter int WAIT_STATES = 0
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [XLEN-3:0] adr_i,
   input  logic [XLEN-1:0] dat_i,
   output logic [XLEN-1:0] dat_o,
   input  logic [3:0]      sel_i,
   input  logic            cyc_i,
   input  logic            stb_i,
   input  logic            we_i,
   output logic            ack_o,
   output logic            err_o
);

   localparam int AW    = XLEN - 2;
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [AW-1:0] BASE_AW  = AW'(BASE_WORD);
   localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH_WORDS);
   localparam logic [3:0]    CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q;
   logic [XLEN-1:0]   dat_q;
   logic [3:0]        sel_q;
   logic              we_q;
   logic              inr_q;

   logic              req;
   logic [AW-1:0]     offset_in;
   logic              inr_in;
   logic              latch;
   logic              access;
   logic [IDX_W-1:0]  acc_idx;
   logic [XLEN-1:0]   acc_dat;
   logic [3:0]        acc_sel;
   logic              acc_we;
   logic              acc_inr;

   logic [XLEN-1:0]   ram [DEPTH_WORDS];

   assign req       = cyc_i & stb_i;
   assign offset_in = adr_i - BASE_AW;
   assign inr_in    = (offset_in < DEPTH_AW);

   // With zero wait states the access happens at the accepting edge, so the
   // access operands come straight from the bus instead of the latched copies.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      access  = 1'b0;
      acc_idx = idx_q;
      acc_dat = dat_q;
      acc_sel = sel_q;
      acc_we  = we_q;
      acc_inr = inr_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               latch = 1'b1;
               if (WAIT_STATES == 0) begin
                  access  = 1'b1;
                  acc_idx = offset_in[IDX_W-1:0];
                  acc_dat = dat_i;
                  acc_sel = sel_i;
                  acc_we  = we_i;
                  acc_inr = inr_in;
                  state_d = ST_RESP;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         inr_q   <= 1'b0;
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
         dat_o   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch) begin
            idx_q <= offset_in[IDX_W-1:0];
            dat_q <= dat_i;
            sel_q <= sel_i;
            we_q  <= we_i;
            inr_q <= inr_in;
         end
         ack_o <= access & acc_inr;
         err_o <= access & ~acc_inr;
         if (access && acc_inr && !acc_we) begin
            dat_o <= ram[acc_idx];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i && access && acc_inr && acc_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (acc_sel[i]) begin
               ram[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: doc/rv32im_bus_responder.md
# rv32im_bus_responder

Wishbone-classic memory responder (slave) that terminates the core's instruction-prefetch, load/store and external-master bus cycles. It decodes a word-address window, serves reads and byte-masked writes from an internal synchronous RAM after a configurable number of wait states, and signals `err_o` for out-of-window accesses. It sits on the shared bus after the core's arbitration mux, one instance per memory region.

## Interface
Parameters:
- XLEN, 32, data width; the address is a word address of XLEN-2 bits.
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two, at least 2.
- BASE_WORD, 0, first word address of the window (byte address >> 2); a multiple of DEPTH_WORDS.
- WAIT_STATES, 0, extra cycles inserted before termination; range 0..15.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- adr_i  in  XLEN-2  word address.
- dat_i  in  XLEN  write data.
- dat_o  out  XLEN  read data; valid while ack_o is high.
- sel_i  in  4  byte lane enables; bit n covers dat bits [8n+7:8n].
- cyc_i  in  1  bus cycle active.
- stb_i  in  1  strobe; a request exists when cyc_i & stb_i.
- we_i  in  1  1 = write, 0 = read.
- ack_o  out  1  normal termination; single-cycle pulse.
- err_o  out  1  error termination; single-cycle pulse; never high together with ack_o.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on an edge with cyc_i & stb_i, latch adr_i, dat_i, sel_i, we_i and the range result.
  - WAIT_STATES = 0: perform the access at that same edge, set ack_o or err_o, go to RESP.
  - Otherwise: load the wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: if ~(cyc_i & stb_i) at an edge, abort: go to IDLE, no access, no termination. Else if counter = 0, perform the access, set ack_o or err_o, go to RESP. Else decrement.
- RESP: ack_o or err_o is high for exactly this cycle. The next edge always returns to IDLE and clears both. Inputs sampled at that edge are ignored, so one request never produces two terminations.
- Range check: offset = adr_i - BASE_WORD, computed as unsigned modulo 2^(XLEN-2). In range iff offset < DEPTH_WORDS. Addresses below BASE_WORD wrap to a large offset and are out of range. RAM index = offset[log2(DEPTH_WORDS)-1:0].
- Read in range: dat_o <= RAM[index]; all four lanes are returned regardless of sel_i.
- Write in range: lanes with sel_i[n] = 1 are updated. sel_i = 4'b0000 still acks and changes nothing. dat_o is unchanged.
- Out of range, read or write: err_o instead of ack_o; no RAM change; dat_o unchanged.
- dat_o holds its last value outside RESP.

## Timing
- Reset values: state IDLE, ack_o = 0, err_o = 0, dat_o = 0, wait counter = 0. RAM contents are not cleared.
- Let edge N be the first IDLE edge with cyc_i & stb_i. ack_o or err_o is high in the cycle following edge N+WAIT_STATES and low after edge N+WAIT_STATES+1.
- Minimum request-to-request spacing is WAIT_STATES+2 cycles. A new request can be accepted at the edge after RESP exits.
- The master must hold adr_i, dat_i, sel_i and we_i stable until termination. The block uses its latched copies, so changes after edge N have no effect.
- Reset mid-WAIT or in RESP: the next cycle is IDLE with outputs deasserted and no write performed. A write committed at an earlier edge persists.
- Reset has priority over any request sampled at the same edge.

## Test plan
- WAIT_STATES=0, BASE_WORD=0: write 0xDEADBEEF to word 5 with sel 4'b1111, then read word 5. Each request gets ack_o exactly 1 cycle after acceptance; the read returns dat_o=0xDEADBEEF; err_o stays 0.
- Byte masking: RAM[5]=0xDEADBEEF, write 0x11223344 with sel 4'b0101, then read. Result is 0xDE22BE44. A write with sel 4'b0000 acks and the read is unchanged.
- WAIT_STATES=3: read accepted at edge N gives ack_o high only in the cycle after edge N+3. stb_i is held high through RESP, and exactly one ack is produced per request.
- Range: DEPTH_WORDS=1024, BASE_WORD=0x400. Accesses to 0x3FF and 0x800 give err_o with no ack_o, and RAM is unchanged. Accesses to 0x400 and 0x7FF ack.
- Abort: WAIT_STATES=4, write request, cyc_i dropped after 2 cycles. No ack_o or err_o, the target word is unchanged, and the next request is accepted normally.
- Reset mid-operation: assert reset_i during WAIT. The next cycle has ack_o=0, err_o=0, dat_o=0, state IDLE, and the pending write is not performed. Previously written words still read back correctly.
